pulse_train_gen: RTL

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of num_pulses pulses. Each pulse is an
// active phase of max(high_len,1) cycles followed by an inactive phase of
// max(low_len,1) cycles. Train parameters are captured on the accepted
// start and held until the train ends or is aborted.
module pulse_train_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic             idle_lvl,
    input  logic             abort,
    output logic             signal,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        INACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // The phase counter holds "cycles remaining after this one", so a phase of
    // length n loads n-1; a length of 0 is treated as 1 and also loads 0.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
        return (len == CNT_ZERO) ? CNT_ZERO : len - CNT_ONE;
    endfunction

    state_t           state_q,    state_d;
    logic             sig_q,      sig_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [CNT_W-1:0] phase_q,    phase_d;
    logic [CNT_W-1:0] pulse_q,    pulse_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic [CNT_W-1:0] cap_low_q,  cap_low_d;
    logic             cap_idle_q, cap_idle_d;

    // Next-state and next-output computation for the train sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        sig_d      = sig_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        phase_d    = phase_q;
        pulse_d    = pulse_q;
        cap_high_d = cap_high_q;
        cap_low_d  = cap_low_q;
        cap_idle_d = cap_idle_q;

        unique case (state_q)
            IDLE: begin
                // Outside a train the output simply tracks idle_lvl one cycle late.
                sig_d  = idle_lvl;
                busy_d = 1'b0;
                if (start) begin
                    if (num_pulses != CNT_ZERO) begin
                        cap_high_d = high_len;
                        cap_low_d  = low_len;
                        cap_idle_d = idle_lvl;
                        phase_d    = phase_load(high_len);
                        pulse_d    = num_pulses;
                        state_d    = ACTIVE;
                        sig_d      = ~idle_lvl;
                        busy_d     = 1'b1;
                    end else begin
                        // An empty train completes immediately without leaving IDLE.
                        done_d = 1'b1;
                    end
                end
            end

            ACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    sig_d   = cap_idle_q;
                    phase_d = CNT_ZERO;
                    pulse_d = CNT_ZERO;
                end else if (phase_q == CNT_ZERO) begin
                    state_d = INACTIVE;
                    sig_d   = cap_idle_q;
                    phase_d = phase_load(cap_low_q);
                end else begin
                    phase_d = phase_q - CNT_ONE;
                end
            end

            INACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    sig_d   = cap_idle_q;
                    phase_d = CNT_ZERO;
                    pulse_d = CNT_ZERO;
                end else if (phase_q == CNT_ZERO) begin
                    if (pulse_q == CNT_ONE) begin
                        // Last pulse finished: leave at the captured level so the
                        // train ends on a clean edge.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sig_d   = cap_idle_q;
                        pulse_d = CNT_ZERO;
                    end else begin
                        state_d = ACTIVE;
                        sig_d   = ~cap_idle_q;
                        phase_d = phase_load(cap_high_q);
                        pulse_d = pulse_q - CNT_ONE;
                    end
                end else begin
                    phase_d = phase_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            sig_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            phase_q    <= CNT_ZERO;
            pulse_q    <= CNT_ZERO;
            cap_high_q <= CNT_ZERO;
            cap_low_q  <= CNT_ZERO;
            cap_idle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            phase_q    <= phase_d;
            pulse_q    <= pulse_d;
            cap_high_q <= cap_high_d;
            cap_low_q  <= cap_low_d;
            cap_idle_q <= cap_idle_d;
        end
    end

    assign signal = sig_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
